dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-port arbiter and sequencer for the byte-addressable data memory (1 KiB, little-endian, write codes 00 none / 01 word / 10 half / 11 byte, combinational 32-bit read).
- Port 0 is the CPU load/store path; port 1 is the debug/loader path.
- The block accepts one request at a time with round-robin priority, checks alignment and bounds, and drives the memory port for exactly one cycle.
- It returns a one-cycle response (read data or write-done, plus error) to the winning requester.

Parameters:
- MEM_BYTES, 1024, memory size in bytes; legal byte addresses are 0..MEM_BYTES-1.
- AW, 32, address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req0, req1  in  1 each  request valid for port 0 / port 1.
- op0, op1  in  2 each  access code: 00 read, 01 sw, 10 sh, 11 sb.
- addr0, addr1  in  AW each  byte address.
- wdata0, wdata1  in  32 each  store data; the low bytes are used for sh/sb.
- gnt0, gnt1  out  1 each  request accepted (registered, one-cycle pulse).
- rvalid0, rvalid1  out  1 each  response valid (one-cycle pulse).
- rdata  out  32  read data, valid with rvalid*.
- err  out  1  access faulted, valid with rvalid*.
- busy  out  1  high when state is not IDLE.
- dm_addr  out  AW  memory address.
- dm_in  out  32  memory write data.
- dm_write  out  2  memory write code.
- dm_out  in  32  memory read data, combinational from dm_addr.

Behaviour:
- rst (async) forces state=IDLE, prio=0, and all of the following to 0: gnt*, rvalid*, rdata, err, busy, dm_addr, dm_in, dm_write. The latched request is discarded.
- States: IDLE -> ACCESS -> RESP -> IDLE. Each state lasts exactly one cycle. Throughput is one access per 3 cycles.
- IDLE:
  - Samples req0/req1 at the clock edge.
  - If none is set, stay in IDLE.
  - If only one is set, that port wins.
  - If both are set, port prio wins.
  - On a win: latch op/addr/wdata and the winner id, and evaluate fault; next state ACCESS; gnt_winner=1 during ACCESS.
- Fault evaluation:
  - op 01: fault if addr[1:0]!=0 or addr>MEM_BYTES-4.
  - op 10: fault if addr[0]!=0 or addr>MEM_BYTES-2.
  - op 11: fault if addr>MEM_BYTES-1.
  - op 00: fault if addr>MEM_BYTES-4. Reads have no alignment requirement.
  - Compare at full AW width; no truncation.
- ACCESS:
  - dm_addr=latched addr and dm_in=latched wdata.
  - dm_write=latched op if the op is a write and no fault; otherwise 00. The memory commits the store at the edge ending ACCESS.
  - For a non-faulting read, capture dm_out into rdata at that edge.
  - For writes or faults, rdata<=0.
  - err<=fault.
  - prio<=~winner.
  - Next state RESP.
- RESP:
  - rvalid_winner=1 for one cycle; rdata and err are stable.
  - dm_write=00.
  - Next state IDLE. Requests are not sampled in RESP.
- Outside ACCESS, dm_write is always 00. dm_addr/dm_in hold their last values, except after reset, when both are 0.
- Requester rule: hold req/op/addr/wdata stable until gnt is seen, then deassert req by the following cycle (RESP). A req still high when the block returns to IDLE is treated as a new request.
- Simultaneous requests always alternate under round-robin, so neither port is starved; the worst-case wait is 3 cycles after the other port's grant.
- Reset asserted in ACCESS means no gnt is seen after reset, and the store may or may not have committed (the memory also clears on rst). Reset asserted in RESP drops rvalid immediately.

Test Plan:
- Single write then read:
  - req0, op=01, addr=0x10, wdata=0xDEADBEEF -> gnt0 in cycle 2, dm_write=01 for one cycle, rvalid0 in cycle 3 with err=0.
  - Then req0 op=00 addr=0x10 -> rdata=0xDEADBEEF.
- Sub-word writes:
  - sh addr=0x20 wdata=0x1234, then sb addr=0x23 wdata=0xAB, then read 0x20 -> rdata=0xAB001234.
- Contention:
  - req0 and req1 held high continuously from reset -> grant order 0,1,0,1.
  - Each gnt is 3 cycles apart, and the rvalid goes only to the granted port.
- Faults, each returning rvalid with err=1, dm_write staying 00, and memory unchanged:
  - sw addr=0x02.
  - sh addr=0x05.
  - sw addr=1021.
  - read addr=1021.
  - sb addr=0x400.
- Boundary legal accesses:
  - sb addr=1023 succeeds, err=0.
  - sw addr=1020 succeeds, err=0.
- Reset mid-operation:
  - Assert rst asynchronously during RESP of a port-1 read -> rvalid1 drops within the same cycle, busy=0, prio=0.
  - Next simultaneous request after reset is granted to port 0.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer for the 1 KiB data memory.
// Each access takes IDLE -> ACCESS -> RESP: grant, one memory cycle, one-cycle response.
//
// state  | meaning
// IDLE   | sample req0/req1, pick a winner, latch its request and fault flag
// ACCESS | drive the memory port for one cycle; gnt of the winner is high
// RESP   | rvalid of the winner is high with rdata/err; requests ignored
module dm_arbiter #(
   parameter int MEM_BYTES = 1024,
   parameter int AW        = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req0,
   input  logic          req1,
   input  logic [1:0]    op0,
   input  logic [1:0]    op1,
   input  logic [AW-1:0] addr0,
   input  logic [AW-1:0] addr1,
   input  logic [31:0]   wdata0,
   input  logic [31:0]   wdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          rvalid0,
   output logic          rvalid1,
   output logic [31:0]   rdata,
   output logic          err,
   output logic          busy,
   output logic [AW-1:0] dm_addr,
   output logic [31:0]   dm_in,
   output logic [1:0]    dm_write,
   input  logic [31:0]   dm_out
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [1:0] OP_RD = 2'b00;
   localparam logic [1:0] OP_SW = 2'b01;
   localparam logic [1:0] OP_SH = 2'b10;
   localparam logic [1:0] OP_SB = 2'b11;

   localparam logic [AW-1:0] LIM_W = AW'(MEM_BYTES - 4);
   localparam logic [AW-1:0] LIM_H = AW'(MEM_BYTES - 2);
   localparam logic [AW-1:0] LIM_B = AW'(MEM_BYTES - 1);

   state_t        state_q, state_d;
   logic          prio_q, prio_d;
   logic          winner_q, winner_d;
   logic [1:0]    op_q, op_d;
   logic          fault_q, fault_d;
   logic          gnt0_q, gnt0_d;
   logic          gnt1_q, gnt1_d;
   logic          rvalid0_q, rvalid0_d;
   logic          rvalid1_q, rvalid1_d;
   logic [31:0]   rdata_q, rdata_d;
   logic          err_q, err_d;
   logic [AW-1:0] dm_addr_q, dm_addr_d;
   logic [31:0]   dm_in_q, dm_in_d;
   logic [1:0]    dm_write_q, dm_write_d;

   logic          win_any;
   logic          win_id;
   logic [1:0]    sel_op;
   logic [AW-1:0] sel_addr;
   logic [31:0]   sel_wdata;
   logic          sel_fault;

   // Winner selection: a lone requester wins, a tie goes to prio.
   always_comb begin
      win_any   = req0 | req1;
      win_id    = (req0 & req1) ? prio_q : req1;
      sel_op    = win_id ? op1    : op0;
      sel_addr  = win_id ? addr1  : addr0;
      sel_wdata = win_id ? wdata1 : wdata0;
      sel_fault = 1'b0;
      case (sel_op)
         OP_SW:   sel_fault = (sel_addr[1:0] != 2'b00) || (sel_addr > LIM_W);
         OP_SH:   sel_fault = sel_addr[0] || (sel_addr > LIM_H);
         OP_SB:   sel_fault = (sel_addr > LIM_B);
         default: sel_fault = (sel_addr > LIM_W);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         prio_q     <= 1'b0;
         winner_q   <= 1'b0;
         op_q       <= OP_RD;
         fault_q    <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         rvalid0_q  <= 1'b0;
         rvalid1_q  <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         dm_addr_q  <= '0;
         dm_in_q    <= '0;
         dm_write_q <= 2'b00;
      end else begin
         state_q    <= state_d;
         prio_q     <= prio_d;
         winner_q   <= winner_d;
         op_q       <= op_d;
         fault_q    <= fault_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         rvalid0_q  <= rvalid0_d;
         rvalid1_q  <= rvalid1_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         dm_addr_q  <= dm_addr_d;
         dm_in_q    <= dm_in_d;
         dm_write_q <= dm_write_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_any) state_d = ACCESS;
         ACCESS:  state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Strobes default low; latched request, rdata/err and memory address/data hold.
   always_comb begin
      prio_d     = prio_q;
      winner_d   = winner_q;
      op_d       = op_q;
      fault_d    = fault_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      dm_addr_d  = dm_addr_q;
      dm_in_d    = dm_in_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      rvalid0_d  = 1'b0;
      rvalid1_d  = 1'b0;
      dm_write_d = 2'b00;
      case (state_q)
         IDLE: begin
            if (win_any) begin
               winner_d   = win_id;
               op_d       = sel_op;
               fault_d    = sel_fault;
               dm_addr_d  = sel_addr;
               dm_in_d    = sel_wdata;
               gnt0_d     = ~win_id;
               gnt1_d     = win_id;
               dm_write_d = (sel_op != OP_RD && !sel_fault) ? sel_op : 2'b00;
            end
         end
         ACCESS: begin
            rdata_d   = (op_q == OP_RD && !fault_q) ? dm_out : 32'd0;
            err_d     = fault_q;
            prio_d    = ~winner_q;
            rvalid0_d = ~winner_q;
            rvalid1_d = winner_q;
         end
         default: ;
      endcase
   end

   assign gnt0     = gnt0_q;
   assign gnt1     = gnt1_q;
   assign rvalid0  = rvalid0_q;
   assign rvalid1  = rvalid1_q;
   assign rdata    = rdata_q;
   assign err      = err_q;
   assign busy     = (state_q != IDLE);
   assign dm_addr  = dm_addr_q;
   assign dm_in    = dm_in_q;
   assign dm_write = dm_write_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a byte-array data memory model.
// Inputs are driven and outputs sampled on the falling edge.
module tb_dm_arbiter;

   logic        clk;
   logic        rst;
   logic        req0, req1;
   logic [1:0]  op0, op1;
   logic [31:0] addr0, addr1;
   logic [31:0] wdata0, wdata1;
   logic        gnt0, gnt1, rvalid0, rvalid1;
   logic [31:0] rdata;
   logic        err;
   logic        busy;
   logic [31:0] dm_addr;
   logic [31:0] dm_in;
   logic [1:0]  dm_write;
   logic [31:0] dm_out;

   int n_cmp;
   int n_bad;

   logic [7:0] mem [1024];
   logic [9:0] ma;

   dm_arbiter #(.MEM_BYTES(1024), .AW(32)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1),
      .op0(op0), .op1(op1),
      .addr0(addr0), .addr1(addr1),
      .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1),
      .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata(rdata), .err(err), .busy(busy),
      .dm_addr(dm_addr), .dm_in(dm_in), .dm_write(dm_write),
      .dm_out(dm_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Little-endian memory, cleared by reset, combinational read.
   assign ma = dm_addr[9:0];
   assign dm_out = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      end else begin
         case (dm_write)
            2'b01: begin
               mem[ma]         <= dm_in[7:0];
               mem[ma + 10'd1] <= dm_in[15:8];
               mem[ma + 10'd2] <= dm_in[23:16];
               mem[ma + 10'd3] <= dm_in[31:24];
            end
            2'b10: begin
               mem[ma]         <= dm_in[7:0];
               mem[ma + 10'd1] <= dm_in[15:8];
            end
            2'b11: mem[ma] <= dm_in[7:0];
            default: ;
         endcase
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // One full transaction on one port; exp_dw is the memory write code expected in ACCESS.
   task automatic xfer(input string tag, input int port, input logic [1:0] op,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] exp_dw, input logic [31:0] exp_rdata,
                       input logic exp_err);
      @(negedge clk);
      if (port == 0) begin
         req0 = 1'b1; op0 = op; addr0 = addr; wdata0 = wdata;
      end else begin
         req1 = 1'b1; op1 = op; addr1 = addr; wdata1 = wdata;
      end
      @(negedge clk);
      chk({tag, ".gnt"}, {30'd0, gnt1, gnt0}, (port == 0) ? 32'd1 : 32'd2);
      chk({tag, ".dm_write"}, {30'd0, dm_write}, {30'd0, exp_dw});
      chk({tag, ".dm_addr"}, dm_addr, addr);
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk({tag, ".rvalid"}, {30'd0, rvalid1, rvalid0}, (port == 0) ? 32'd1 : 32'd2);
      chk({tag, ".rdata"}, rdata, exp_rdata);
      chk({tag, ".err"}, {31'd0, err}, {31'd0, exp_err});
      chk({tag, ".resp_dw"}, {30'd0, dm_write}, 32'd0);
      @(negedge clk);
      chk({tag, ".idle"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      op0 = 2'b00; op1 = 2'b00;
      addr0 = '0; addr1 = '0;
      wdata0 = '0; wdata1 = '0;
      #12;
      chk("rst.strobes", {28'd0, gnt0, gnt1, rvalid0, rvalid1}, 32'd0);
      chk("rst.busy_err", {30'd0, busy, err}, 32'd0);
      chk("rst.rdata", rdata, 32'd0);
      chk("rst.dm_addr", dm_addr, 32'd0);
      chk("rst.dm_in", dm_in, 32'd0);
      chk("rst.dm_write", {30'd0, dm_write}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Word write and read back, plus an unaligned legal read
      xfer("sw10",  0, 2'b01, 32'h10, 32'hDEADBEEF, 2'b01, 32'h0,        1'b0);
      xfer("rd10",  0, 2'b00, 32'h10, 32'h0,        2'b00, 32'hDEADBEEF, 1'b0);
      xfer("rd11",  1, 2'b00, 32'h11, 32'h0,        2'b00, 32'h00DEADBE, 1'b0);

      // Sub-word writes merge into one word
      xfer("sh20",  0, 2'b10, 32'h20, 32'h00001234, 2'b10, 32'h0,        1'b0);
      xfer("sb23",  1, 2'b11, 32'h23, 32'h000000AB, 2'b11, 32'h0,        1'b0);
      xfer("rd20",  0, 2'b00, 32'h20, 32'h0,        2'b00, 32'hAB001234, 1'b0);

      // Faults: no write, zero rdata, memory untouched
      xfer("f_sw02",  0, 2'b01, 32'h02,       32'hFFFFFFFF, 2'b00, 32'h0, 1'b1);
      xfer("f_sh05",  1, 2'b10, 32'h05,       32'hFFFFFFFF, 2'b00, 32'h0, 1'b1);
      xfer("f_sw1021",0, 2'b01, 32'd1021,     32'hFFFFFFFF, 2'b00, 32'h0, 1'b1);
      xfer("f_rd1021",1, 2'b00, 32'd1021,     32'h0,        2'b00, 32'h0, 1'b1);
      xfer("f_sb400", 0, 2'b11, 32'h400,      32'hFFFFFFFF, 2'b00, 32'h0, 1'b1);
      xfer("f_rdhigh",0, 2'b00, 32'hFFFFFFFC, 32'h0,        2'b00, 32'h0, 1'b1);
      xfer("rd00",    0, 2'b00, 32'h00,       32'h0,        2'b00, 32'h0, 1'b0);
      xfer("rd04",    1, 2'b00, 32'h04,       32'h0,        2'b00, 32'h0, 1'b0);
      xfer("rd1020a", 0, 2'b00, 32'd1020,     32'h0,        2'b00, 32'h0, 1'b0);

      // Boundary legal accesses
      xfer("sb1023",  1, 2'b11, 32'd1023, 32'h0000005A, 2'b11, 32'h0,        1'b0);
      xfer("rd1020b", 0, 2'b00, 32'd1020, 32'h0,        2'b00, 32'h5A000000, 1'b0);
      xfer("sw1020",  0, 2'b01, 32'd1020, 32'h11223344, 2'b01, 32'h0,        1'b0);
      xfer("rd1020c", 1, 2'b00, 32'd1020, 32'h0,        2'b00, 32'h11223344, 1'b0);

      // Contention from reset: grants alternate 0,1,0,1 three cycles apart
      rst = 1'b1;
      req0 = 1'b1; req1 = 1'b1;
      op0 = 2'b00; op1 = 2'b00;
      addr0 = 32'h0; addr1 = 32'h4;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 12; i++) begin
         logic [3:0] exp_v;
         @(negedge clk);
         exp_v = {(i % 6 == 0), (i % 6 == 3), (i % 6 == 1), (i % 6 == 4)};
         chk($sformatf("rr.c%0d", i), {28'd0, gnt0, gnt1, rvalid0, rvalid1}, {28'd0, exp_v});
      end
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      @(negedge clk);

      // Reset during RESP of a port-1 read
      @(negedge clk);
      req1 = 1'b1; op1 = 2'b00; addr1 = 32'h10;
      @(negedge clk);
      chk("mid.gnt1", {31'd0, gnt1}, 32'd1);
      req1 = 1'b0;
      @(negedge clk);
      chk("mid.rvalid1", {31'd0, rvalid1}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid.rvalid1_drop", {31'd0, rvalid1}, 32'd0);
      chk("mid.busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      req0 = 1'b1; req1 = 1'b1;
      op0 = 2'b00; op1 = 2'b00;
      addr0 = 32'h8; addr1 = 32'hC;
      @(negedge clk);
      chk("post_rst.gnt", {30'd0, gnt1, gnt0}, 32'd1);
      req0 = 1'b0; req1 = 1'b0;
      @(negedge clk);
      chk("post_rst.rvalid", {30'd0, rvalid1, rvalid0}, 32'd1);
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
